// File: rtl/weight_loader_pkg.sv
// rtl/weight_loader_pkg.sv - shared CNN constants and weight loader state encoding
package weight_loader_pkg;

    // Taps in one 5x5 kernel; also sizes the weight bank and conv datapath.
    localparam int KERNEL_TAPS   = 25;
    localparam int WEIGHT_DW     = 32;
    localparam int WEIGHT_MEM_AW = 12;
    localparam int BANK_AW       = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } wl_state_e;

endpackage

// File: rtl/weight_loader_if.sv
// rtl/weight_loader_if.sv - control, weight memory and weight bank signals of the loader
interface weight_loader_if
    import weight_loader_pkg::*;
#(
    parameter int MEM_AW = WEIGHT_MEM_AW,
    parameter int DW     = WEIGHT_DW
);

    logic              iStart;
    logic [MEM_AW-1:0] iBase;
    logic              iHold;
    logic              oMemRd;
    logic [MEM_AW-1:0] oMemAddr;
    logic [DW-1:0]     iMemData;
    logic              oWren;
    logic [BANK_AW-1:0] oAddr;
    logic [DW-1:0]     oW;
    logic              oBusy;
    logic              oDone;

    // Loader side.
    modport master (
        input  iStart, iBase, iHold, iMemData,
        output oMemRd, oMemAddr, oWren, oAddr, oW, oBusy, oDone
    );

    // Layer controller / memory / bank side.
    modport slave (
        output iStart, iBase, iHold, iMemData,
        input  oMemRd, oMemAddr, oWren, oAddr, oW, oBusy, oDone
    );

endinterface

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams NUM_W weights from weight memory into the kernel weight bank
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int NUM_W  = KERNEL_TAPS,
    parameter int MEM_AW = WEIGHT_MEM_AW,
    parameter int DW     = WEIGHT_DW
) (
    input  logic             clk,
    input  logic             rst,
    weight_loader_if.master  bus
);

    localparam logic [BANK_AW-1:0] LAST_IDX = BANK_AW'(NUM_W - 1);

    wl_state_e          state_q, state_d;
    logic [BANK_AW-1:0] idx_q, idx_d;
    logic [MEM_AW-1:0]  base_q, base_d;
    logic               wr_pend_q, wr_pend_d;
    logic [BANK_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]      w_last_q, w_last_d;
    logic               mem_rd;

    // Next state: read issue in RUN, one-cycle write follow-up, hold-last-value for oW.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        w_last_d  = w_last_q;
        mem_rd    = 1'b0;

        // Remember the word being written so oW holds it once oWren drops.
        if (wr_pend_q) begin
            w_last_d = bus.iMemData;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    base_d  = bus.iBase;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.iHold) begin
                    mem_rd    = 1'b1;
                    wr_pend_d = 1'b1;
                    wr_addr_d = idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_LAST;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LAST: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pipeline registers; reset abandons any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            w_last_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            w_last_q  <= w_last_d;
        end
    end

    // Memory address wraps modulo 2^MEM_AW by truncation of the sum.
    assign bus.oMemRd   = mem_rd;
    assign bus.oMemAddr = base_q + MEM_AW'(idx_q);

    // Read data lands one cycle after the strobe and goes straight to the bank.
    assign bus.oWren = wr_pend_q;
    assign bus.oAddr = wr_addr_q;
    assign bus.oW    = wr_pend_q ? bus.iMemData : w_last_q;

    assign bus.oBusy = (state_q == ST_RUN) || (state_q == ST_LAST);
    assign bus.oDone = (state_q == ST_DONE);

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side initiator for the CNN 5x5 kernel weight bank.
- Fetches NUM_W consecutive 32-bit signed weights from a synchronous weight memory, starting at a caller-supplied base address.
- Drives them into the bank's write port as (oWren, oAddr, oW), using bank addresses 0..NUM_W-1.
- Sits between the layer controller (start/done) and the weight memory / weight bank pair.

Parameters:
- NUM_W, 25, number of weights per kernel load; bank addresses 0..NUM_W-1.
- MEM_AW, 12, weight memory address width.
- DW, 32, weight data width (signed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- iStart  in  1  load request; sampled only in IDLE.
- iBase  in  MEM_AW  memory address of weight 0; captured with iStart.
- iHold  in  1  memory arbitration stall; while 1, no new read is issued.
- oMemRd  out  1  memory read strobe.
- oMemAddr  out  MEM_AW  memory read address.
- iMemData  in  DW  read data, valid exactly 1 cycle after oMemRd.
- oWren  out  1  bank write enable.
- oAddr  out  10  bank address, zero-extended index.
- oW  out  DW  bank write data.
- oBusy  out  1  high from the cycle after start acceptance until the last write.
- oDone  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset: all outputs 0, state IDLE, read index 0, pending-write flag 0. Reset mid-load aborts immediately: no further oWren or oMemRd, no oDone.
- FSM states:
  - IDLE: iStart=1 latches iBase, clears index, goes to RUN. iStart in any other state is ignored; it is neither queued nor restarted.
  - RUN: each cycle with iHold=0, assert oMemRd with oMemAddr=base+idx, then idx++. The address is computed modulo 2^MEM_AW, so it wraps silently. After issuing idx=NUM_W-1, go to LAST.
  - LAST: no reads; the final write occurs here; then go to DONE.
  - DONE: oDone=1 for exactly this cycle, oBusy=0, then IDLE. A new iStart is accepted on the following IDLE cycle at the earliest.
- Write pipeline:
  - A read issued in cycle t produces oWren=1 in cycle t+1, with oAddr equal to the index of that read and oW=iMemData passed through combinationally. No extra register stage.
  - This stage is unaffected by iHold: an in-flight read is always written.
- iHold:
  - Only suppresses new reads; idx and base are frozen.
  - iHold asserted in the cycle after the last read has no effect, because the FSM is already in LAST.
- Latency with no hold: iStart accepted at cycle 0; reads in cycles 1..NUM_W; writes in cycles 2..NUM_W+1; oDone in cycle NUM_W+2.
- Each stall cycle extends the load by exactly one cycle.
- Writes are strictly in ascending oAddr order, exactly NUM_W per load, never duplicated.
- oAddr and oW hold their last values when oWren=0. Only oWren qualifies them.
- oBusy: 1 in RUN and LAST, 0 in IDLE and DONE.

Decomposition:
- Shared CNN package holds:
  - state encoding (IDLE, RUN, LAST, DONE);
  - KERNEL_TAPS=25 constant, shared with the weight bank and conv datapath;
  - weight width constant (32).
- No sub-module needed. The index counter and FSM live in one module, targeting about 150 lines of RTL.

Test Plan:
- Basic load: memory[100+k]=k*3-7; iBase=100, iStart pulse at cycle 0 -> 25 writes in cycles 2..26 with oAddr=k, oW=3k-7; oDone pulse in cycle 27; bank readback w1=-7, w25=65.
- Hold: iHold=1 for 3 cycles after the 5th read -> no oMemRd during hold; write of k=4 still occurs; oDone at cycle 30; data identical to basic load.
- Address wrap: iBase=4090 with MEM_AW=12 -> reads 4090..4095 then 0..18; oAddr 0..24 contiguous; oDone at cycle 27.
- Start while busy: second iStart with iBase=0 at cycle 10 -> ignored; exactly 25 writes from base 100; one oDone.
- Reset mid-load: rst=1 at cycle 12 for 1 cycle -> oWren, oMemRd, oBusy all 0 from cycle 13; no oDone; a subsequent iStart performs a full clean load.
- Back-to-back: iStart held continuously high -> loads are separated by the DONE cycle plus one IDLE cycle; each load produces 25 writes and one oDone.
